// File: rtl/layer_arb_pkg.sv
// Shared types and helpers for the two-requester layer arbiter.
package layer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int TAGW = 1;

    // rr_last names the requester served last; on a tie the other one wins.
    function automatic logic rr_pick1(input logic v0, input logic v1, input logic rr_last);
        return v1 && (!v0 || !rr_last);
    endfunction

endpackage

// File: rtl/layer_arb_tag_fifo.sv
// Order FIFO holding the owner tag of every vector currently inside the layer.
module layer_arb_tag_fifo
    import layer_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [TAGW-1:0] din_i,
    input  logic            pop_i,
    output logic [TAGW-1:0] dout_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [TAGW-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push_s;
    logic            do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == CW'(0));
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q];

    // Occupancy next-state: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Storage and pointers; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAGW'(0);
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/layer_arb_2.sv
// Shares one layer datapath between two streams, whole vectors at a time.
// Define LAYER_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module layer_arb_2
    import layer_arb_pkg::*;
#(
    parameter int T        = 16,
    parameter int N        = 3,
    parameter int M        = 3,
    parameter int TAGDEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic [T-1:0] s0_data,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic [T-1:0] s1_data,
    output logic         l_s_valid,
    input  logic         l_s_ready,
    output logic [T-1:0] l_s_data,
    input  logic         l_m_valid,
    output logic         l_m_ready,
    input  logic [T-1:0] l_m_data,
    output logic         m0_valid,
    input  logic         m0_ready,
    output logic [T-1:0] m0_data,
    output logic         m1_valid,
    input  logic         m1_ready,
    output logic [T-1:0] m1_data
);

    localparam int ICW = (N > 1) ? $clog2(N) : 1;
    localparam int OCW = (M > 1) ? $clog2(M) : 1;

    arb_state_t      state_q;
    logic [ICW-1:0]  in_cnt_q;
    logic [OCW-1:0]  out_cnt_q;
    logic            rr_last_s;
    logic            pick1_s;
    logic            push_s;
    logic            pop_s;
    logic            in_fire_s;
    logic            last_in_s;
    logic            out_fire_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [TAGW-1:0] head_s;

`ifdef LAYER_ARB_FIXED_PRIO_EN
    assign rr_last_s = 1'b1;
`else
    logic rr_last_q;
    assign rr_last_s = rr_last_q;

    // Remember who finished the last vector for round-robin tie breaks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= 1'b1;
        end else if (last_in_s) begin
            rr_last_q <= (state_q == GRANT1);
        end
    end
`endif

    assign pick1_s    = rr_pick1(s0_valid, s1_valid, rr_last_s);
    assign push_s     = (state_q == IDLE) && (s0_valid || s1_valid) && !fifo_full_s;
    assign in_fire_s  = l_s_valid && l_s_ready;
    assign last_in_s  = in_fire_s && (in_cnt_q == ICW'(N - 1));
    assign out_fire_s = l_m_valid && l_m_ready;
    assign pop_s      = out_fire_s && (out_cnt_q == OCW'(M - 1));

    layer_arb_tag_fifo #(.DEPTH(TAGDEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push_s),
        .din_i   (pick1_s),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Input mux: only the granted requester sees the layer's ready.
    always_comb begin
        l_s_valid = 1'b0;
        l_s_data  = {T{1'b0}};
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        case (state_q)
            GRANT0: begin
                l_s_valid = s0_valid;
                l_s_data  = s0_data;
                s0_ready  = l_s_ready;
            end
            GRANT1: begin
                l_s_valid = s1_valid;
                l_s_data  = s1_data;
                s1_ready  = l_s_ready;
            end
            default: begin
                l_s_valid = 1'b0;
                l_s_data  = {T{1'b0}};
            end
        endcase
    end

    // Output demux steered by the oldest tag still in the layer.
    always_comb begin
        m0_valid  = 1'b0;
        m1_valid  = 1'b0;
        l_m_ready = 1'b0;
        m0_data   = l_m_data;
        m1_data   = l_m_data;
        if (fifo_empty_s) begin
            l_m_ready = 1'b0;
        end else if (head_s == 1'b0) begin
            m0_valid  = l_m_valid;
            l_m_ready = m0_ready;
        end else begin
            m1_valid  = l_m_valid;
            l_m_ready = m1_ready;
        end
    end

    // Grant FSM: a grant is held until the vector's last word is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            in_cnt_q <= ICW'(0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (push_s) begin
                        state_q <= pick1_s ? GRANT1 : GRANT0;
                    end
                end
                GRANT0, GRANT1: begin
                    if (last_in_s) begin
                        in_cnt_q <= ICW'(0);
                        state_q  <= IDLE;
                    end else if (in_fire_s) begin
                        in_cnt_q <= in_cnt_q + ICW'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    in_cnt_q <= ICW'(0);
                end
            endcase
        end
    end

    // Output word counter; the tag retires with the vector's last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt_q <= OCW'(0);
        end else if (pop_s) begin
            out_cnt_q <= OCW'(0);
        end else if (out_fire_s) begin
            out_cnt_q <= out_cnt_q + OCW'(1);
        end
    end

endmodule

// File: tb/tb_layer_arb_2.sv
// Bench for layer_arb_2: vector table, directed corner sequences and random traffic
// against a per-requester scoreboard with an "add 0x0100" layer model.
module tb_layer_arb_2;

    localparam int T        = 16;
    localparam int N        = 3;
    localparam int M        = 3;
    localparam int TAGDEPTH = 4;

    logic         clk;
    logic         reset_n;
    logic         s0_valid, s0_ready, s1_valid, s1_ready;
    logic [T-1:0] s0_data, s1_data;
    logic         l_s_valid, l_s_ready, l_m_valid, l_m_ready;
    logic [T-1:0] l_s_data, l_m_data;
    logic         m0_valid, m0_ready, m1_valid, m1_ready;
    logic [T-1:0] m0_data, m1_data;

    layer_arb_2 #(.T(T), .N(N), .M(M), .TAGDEPTH(TAGDEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
        .l_s_valid(l_s_valid), .l_s_ready(l_s_ready), .l_s_data(l_s_data),
        .l_m_valid(l_m_valid), .l_m_ready(l_m_ready), .l_m_data(l_m_data),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                 req;
        logic [N-1:0][T-1:0]  d;   // element [0] is the first word sent
        logic [M-1:0][T-1:0]  e;   // element [0] is the first word expected back
    } vec_rec_t;

    vec_rec_t     tbl [5];
    logic [T-1:0] src0_q[$], src1_q[$], exp0_q[$], exp1_q[$], got0_q[$], got1_q[$], layer_q[$];
    int           vec_owner[$];
    int           lin_words, cur_owner, acc0, acc1, vecs_in, mwords_out;
    int           gap0, gap1, pls, plm, pm0, pm1;
    bit           en0, en1, s0_block;
    int           vectors, miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
        got0_q.delete(); got1_q.delete(); layer_q.delete(); vec_owner.delete();
        lin_words = 0; cur_owner = 0; acc0 = 0; acc1 = 0; vecs_in = 0; mwords_out = 0;
        gap0 = 0; gap1 = 0; pls = 100; plm = 100; pm0 = 100; pm1 = 100;
        en0 = 1'b0; en1 = 1'b0; s0_block = 1'b0;
    endtask

    task automatic drive_idle();
        s0_valid = 1'b0; s1_valid = 1'b0; s0_data = 16'h0; s1_data = 16'h0;
        l_s_ready = 1'b0; l_m_valid = 1'b0; l_m_data = 16'h0; m0_ready = 1'b0; m1_ready = 1'b0;
    endtask

    function automatic logic [31:0] outs_vec();
        return {26'd0, s0_ready, s1_ready, l_s_valid, l_m_ready, m0_valid, m1_valid};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 16'h1111; s1_data = 16'h2222;
        l_s_ready = 1'b1; l_m_valid = 1'b1; l_m_data = 16'h3333; m0_ready = 1'b1; m1_ready = 1'b1;
        #1;
        chk("reset_outputs", outs_vec(), 32'd0);
        clear_model();
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load(input int r, input logic [T-1:0] base, input int nvec);
        for (int i = 0; i < nvec * N; i++) begin
            if (r == 0) src0_q.push_back(base + T'(i));
            else        src1_q.push_back(base + T'(i));
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, update the model for the coming edge.
    task automatic cyc();
        bit f0, f1, fl, fm0, fm1, flm;
        int own;
        @(negedge clk);
        s0_valid  = en0 && !s0_block && (src0_q.size() > 0) && ($urandom_range(99) >= gap0);
        s0_data   = (src0_q.size() > 0) ? src0_q[0] : 16'h0;
        s1_valid  = en1 && (src1_q.size() > 0) && ($urandom_range(99) >= gap1);
        s1_data   = (src1_q.size() > 0) ? src1_q[0] : 16'h0;
        l_s_ready = ($urandom_range(99) < pls);
        l_m_valid = (layer_q.size() > 0) && ($urandom_range(99) < plm);
        l_m_data  = (layer_q.size() > 0) ? layer_q[0] : 16'h0;
        m0_ready  = ($urandom_range(99) < pm0);
        m1_ready  = ($urandom_range(99) < pm1);
        #1;
        f0  = s0_valid && s0_ready;   f1  = s1_valid && s1_ready;   fl  = l_s_valid && l_s_ready;
        fm0 = m0_valid && m0_ready;   fm1 = m1_valid && m1_ready;   flm = l_m_valid && l_m_ready;
        chk("ready_excl", 32'(s0_ready & s1_ready), 32'd0);
        chk("m_valid_excl", 32'(m0_valid & m1_valid), 32'd0);
        chk("in_fire", 32'(fl), 32'(f0 | f1));
        chk("out_fire", 32'(flm), 32'(fm0 | fm1));
        if (fm0) begin
            got0_q.push_back(m0_data); mwords_out++;
            chk("m0_extra", 32'(exp0_q.size() == 0), 32'd0);
            if (exp0_q.size() > 0) chk("m0_data", m0_data, exp0_q.pop_front());
        end
        if (fm1) begin
            got1_q.push_back(m1_data); mwords_out++;
            chk("m1_extra", 32'(exp1_q.size() == 0), 32'd0);
            if (exp1_q.size() > 0) chk("m1_data", m1_data, exp1_q.pop_front());
        end
        if (flm && layer_q.size() > 0) void'(layer_q.pop_front());
        if (f0) begin exp0_q.push_back(s0_data + 16'h0100); void'(src0_q.pop_front()); acc0++; end
        if (f1) begin exp1_q.push_back(s1_data + 16'h0100); void'(src1_q.pop_front()); acc1++; end
        if (fl) begin
            chk("in_data", l_s_data, f1 ? s1_data : s0_data);
            own = f1 ? 1 : 0;
            if (lin_words % N == 0) begin
                vec_owner.push_back(own); vecs_in++; cur_owner = own;
            end else begin
                chk("vector_atomic", own, cur_owner);
            end
            lin_words++;
            layer_q.push_back(l_s_data + 16'h0100);
        end
        chk("inflight_max", 32'((vecs_in - mwords_out / M) > TAGDEPTH), 32'd0);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size() + layer_q.size()) != 0
               && c < budget) begin
            cyc();
            c++;
        end
        chk("drain_left", src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size() + layer_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n;
        vectors = 0; miscompares = 0;
        reset_n = 1'b0;
        clear_model();
        drive_idle();

        tbl[0] = '{req: 1'b0, d: {16'd3, 16'd2, 16'd1},             e: {16'h0103, 16'h0102, 16'h0101}};
        tbl[1] = '{req: 1'b0, d: {16'd6, 16'd5, 16'd4},             e: {16'h0106, 16'h0105, 16'h0104}};
        tbl[2] = '{req: 1'b1, d: {16'h00C0, 16'h00B0, 16'h00A0},    e: {16'h01C0, 16'h01B0, 16'h01A0}};
        tbl[3] = '{req: 1'b1, d: {16'h8000, 16'h0000, 16'hFFFF},    e: {16'h8100, 16'h0100, 16'h00FF}};
        tbl[4] = '{req: 1'b0, d: {16'h0001, 16'h7FFF, 16'hFF00},    e: {16'h0101, 16'h80FF, 16'h0000}};

        // Table: one vector per record, results land only on the owner's stream.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            got0_q.delete(); got1_q.delete();
            for (int k = 0; k < N; k++) begin
                if (tbl[r].req) src1_q.push_back(tbl[r].d[k]);
                else            src0_q.push_back(tbl[r].d[k]);
            end
            en0 = 1'b1; en1 = 1'b1;
            drain(50);
            chk("tbl_count", tbl[r].req ? got1_q.size() : got0_q.size(), M);
            chk("tbl_other_empty", tbl[r].req ? got0_q.size() : got1_q.size(), 0);
            for (int k = 0; k < M; k++) begin
                if (tbl[r].req && k < got1_q.size())       chk("tbl_word", got1_q[k], tbl[r].e[k]);
                else if (!tbl[r].req && k < got0_q.size()) chk("tbl_word", got0_q[k], tbl[r].e[k]);
            end
        end

        // Both requesters saturated: grant order and one bubble per vector.
        do_reset();
        load(0, 16'h1000, 4);
        load(1, 16'h2000, 4);
        en0 = 1'b1; en1 = 1'b1;
        c = 0;
        while ((src0_q.size() + src1_q.size()) != 0 && c < 200) begin cyc(); c++; end
        chk("throughput_cycles", c, 8 * (N + 1));
        drain(100);
        chk("grant_count", vec_owner.size(), 8);
        for (int k = 0; k < 8 && k < vec_owner.size(); k++) begin
`ifdef LAYER_ARB_FIXED_PRIO_EN
            chk("grant_order", vec_owner[k], (k < 4) ? 0 : 1);
`else
            chk("grant_order", vec_owner[k], k % 2);
`endif
        end
        chk("sat_m0_words", got0_q.size(), 4 * M);
        chk("sat_m1_words", got1_q.size(), 4 * M);

        // Result back-pressure: the order FIFO fills and the fifth grant is withheld.
        do_reset();
        load(0, 16'h3000, 5);
        en0 = 1'b1; pm0 = 0;
        repeat (20) cyc();
        chk("bp_vecs_in", vecs_in, TAGDEPTH);
        chk("bp_unsent", src0_q.size(), N);
        chk("bp_s0_ready", s0_ready, 1'b0);
        chk("bp_nothing_out", got0_q.size(), 0);
        pm0 = 100;
        drain(100);
        chk("bp_drained", got0_q.size(), 5 * M);

        // Mid-vector upstream stall holds the grant; the other requester waits.
        do_reset();
        load(0, 16'h4000, 1);
        load(1, 16'h4100, 1);
        en0 = 1'b1; en1 = 1'b1;
        c = 0;
        while (acc0 < 1 && c < 20) begin cyc(); c++; end
        chk("stall_first_word", acc0, 1);
        s0_block = 1'b1;
        repeat (5) cyc();
        chk("stall_other_waits", acc1, 0);
        s0_block = 1'b0;
        c = 0;
        while (acc0 < N && c < 20) begin cyc(); c++; end
        chk("stall_other_still_waits", acc1, 0);
        drain(60);
        chk("stall_vec_count", vec_owner.size(), 2);
        if (vec_owner.size() == 2) begin
            chk("stall_owner0", vec_owner[0], 0);
            chk("stall_owner1", vec_owner[1], 1);
        end

        // Reset pulse while word 2 is on the bus; outputs drop in the same cycle.
        do_reset();
        load(0, 16'h5000, 2);
        en0 = 1'b1;
        c = 0;
        while (acc0 < 1 && c < 20) begin cyc(); c++; end
        chk("rst_first_word", acc0, 1);
        @(negedge clk);
        s0_valid = 1'b1; s0_data = src0_q[0]; l_s_ready = 1'b1; m0_ready = 1'b1; m1_ready = 1'b1;
        l_m_valid = (layer_q.size() > 0);
        l_m_data  = (layer_q.size() > 0) ? layer_q[0] : 16'h0;
        #1;
        chk("rst_pre_l_s_valid", l_s_valid, 1'b1);
        chk("rst_pre_m0_valid", m0_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", outs_vec(), 32'd0);
        clear_model();
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
        load(0, 16'h5100, 1);
        en0 = 1'b1;
        drain(60);
        chk("post_rst_m0_words", got0_q.size(), M);
        chk("post_rst_m1_words", got1_q.size(), 0);

        // Random traffic and handshakes, checked by the scoreboard inside cyc().
        for (int round = 0; round < 4; round++) begin
            do_reset();
            gap0 = $urandom_range(40); gap1 = $urandom_range(40);
            pls = $urandom_range(100, 40); plm = $urandom_range(100, 40);
            pm0 = $urandom_range(100, 30); pm1 = $urandom_range(100, 30);
            n = $urandom_range(12, 4);
            for (int i = 0; i < n * N; i++) src0_q.push_back(T'($urandom));
            n = $urandom_range(12, 4);
            for (int i = 0; i < n * N; i++) src1_q.push_back(T'($urandom));
            en0 = 1'b1; en1 = 1'b1;
            drain(3000);
            chk("rand_out_words", mwords_out, lin_words);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
